// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter (8N1) that takes en/RST from the power-up delay stage.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
) (
   input  logic       sys_clk,
   input  logic       RST,
   input  logic       en,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       txd
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             txd_nxt, ready_nxt, busy_nxt;
   logic             bit_done, accept;
`ifdef UART_TX_PARITY_EN
   logic             par, par_nxt;
`endif

   assign bit_done = (cnt == CNT_LAST);
   // tx_ready is registered, so an accept reflects the previous cycle's en.
   assign accept   = tx_valid & tx_ready;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      txd_nxt     = txd;
      busy_nxt    = tx_busy;
`ifdef UART_TX_PARITY_EN
      par_nxt     = par;
`endif
      if (state != IDLE)
         cnt_nxt = bit_done ? '0 : cnt + CNT_W'(1);

      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = START;
               shreg_nxt   = tx_data;
               txd_nxt     = 1'b0;
               busy_nxt    = 1'b1;
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
               par_nxt     = ^tx_data;
`endif
            end
         end
         START: begin
            if (bit_done) begin
               state_nxt = DATA;
               txd_nxt   = shreg[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx == 3'd7) begin
                  bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt   = PARITY;
                  txd_nxt     = par;
`else
                  state_nxt   = STOP;
                  txd_nxt     = 1'b1;
`endif
               end else begin
                  // shreg[0] is always the bit currently on the line
                  bit_idx_nxt = bit_idx + 3'd1;
                  shreg_nxt   = {1'b0, shreg[7:1]};
                  txd_nxt     = shreg[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_nxt = STOP;
               txd_nxt   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               txd_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase

      ready_nxt = (state_nxt == IDLE) && en;
   end

   // Control state; RST aborts any frame in flight and parks the line high.
   always_ff @(posedge sys_clk) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         txd      <= 1'b1;
         tx_ready <= 1'b0;
         tx_busy  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         txd      <= txd_nxt;
         tx_ready <= ready_nxt;
         tx_busy  <= busy_nxt;
      end
   end

   // Data path carries no reset; it is only observed after a fresh accept.
   always_ff @(posedge sys_clk) begin
      shreg <= shreg_nxt;
`ifdef UART_TX_PARITY_EN
      par   <= par_nxt;
`endif
   end

endmodule
